// File: rtl/debounce_fsm.sv
`default_nettype none
// ============================================================================
// Module      : debounce_fsm
// Description : Debouncer for a raw mechanical switch / pushbutton input.
//               The asynchronous input is brought into the clk domain through
//               a two-flop synchroniser. A new level is accepted only after
//               the synchronised sample has held it for DB_CYCLES consecutive
//               clocks. The result is a clean, registered level for the
//               downstream edge detector.
// Ports       : clk      - system clock, rising edge
//               reset    - asynchronous, active-low reset
//               sw       - raw switch input (asynchronous, may bounce)
//               db_level - debounced level (registered)
//               db_busy  - high while a candidate level change is timed
//                          (registered)
// Parameters  : DB_CYCLES - consecutive stable samples needed (>= 2)
//               CNT_W     - stability counter width, 2**CNT_W >= DB_CYCLES
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_fsm #(
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic db_level,
    output logic db_busy
);

    typedef enum logic [1:0] {
        ST_ZERO  = 2'd0,
        ST_WAIT1 = 2'd1,
        ST_ONE   = 2'd2,
        ST_WAIT0 = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    logic             r_s1;
    logic             r_sw_s;
    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_db_level;
    logic             r_db_busy;
    logic             w_level_next;
    logic             w_busy_next;

    // Two-flop synchroniser; the FSM only ever looks at r_sw_s.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1   <= 1'b0;
            r_sw_s <= 1'b0;
        end else begin
            r_s1   <= sw;
            r_sw_s <= r_s1;
        end
    end

    // State, counter and output registers all update on the same edge, so
    // the outputs are glitch-free and never combinationally follow sw.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_ZERO;
            r_cnt      <= '0;
            r_db_level <= 1'b0;
            r_db_busy  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_db_level <= w_level_next;
            r_db_busy  <= w_busy_next;
        end
    end

    // Next-state logic. In the wait states the revert test comes first so
    // that a sample back at the old level aborts even on the terminal count.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_ZERO: begin
                if (r_sw_s) begin
                    w_state_next = ST_WAIT1;
                    w_cnt_next   = '0;
                end
            end
            ST_WAIT1: begin
                if (!r_sw_s) begin
                    w_state_next = ST_ZERO;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_state_next = ST_ONE;
                end else begin
                    w_cnt_next = r_cnt + C_CNT_ONE;
                end
            end
            ST_ONE: begin
                if (!r_sw_s) begin
                    w_state_next = ST_WAIT0;
                    w_cnt_next   = '0;
                end
            end
            ST_WAIT0: begin
                if (r_sw_s) begin
                    w_state_next = ST_ONE;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_state_next = ST_ZERO;
                end else begin
                    w_cnt_next = r_cnt + C_CNT_ONE;
                end
            end
            default: begin
                w_state_next = ST_ZERO;
            end
        endcase
    end

    // Outputs are registered from the state being entered.
    always_comb begin
        w_level_next = (w_state_next == ST_ONE)   || (w_state_next == ST_WAIT0);
        w_busy_next  = (w_state_next == ST_WAIT1) || (w_state_next == ST_WAIT0);
    end

    assign db_level = r_db_level;
    assign db_busy  = r_db_busy;

endmodule
`default_nettype wire

// File: tb/tb_debounce_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_fsm
// Description : Directed self-checking bench for debounce_fsm with
//               DB_CYCLES = 4, CNT_W = 3. Inputs change 1 time unit after a
//               rising edge; outputs are sampled at that same point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_fsm;

    localparam int DB_CYCLES = 4;
    localparam int CNT_W     = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic sw    = 1'b0;
    logic db_level;
    logic db_busy;

    int n_checks = 0;
    int n_errors = 0;

    debounce_fsm #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .sw       (sw),
        .db_level (db_level),
        .db_busy  (db_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic lvl, input logic busy);
        check({tag, ".level"}, {31'd0, db_level}, {31'd0, lvl});
        check({tag, ".busy"},  {31'd0, db_busy},  {31'd0, busy});
    endtask

    // Present sw for the next rising edge, then move 1 unit past that edge.
    task automatic cyc(input logic v);
        sw = v;
        @(posedge clk);
        #1;
    endtask

    logic [11:0] bounce_pat;
    logic [11:0] bounce_busy;
    logic [4:0]  glitch_pat;
    logic [4:0]  glitch_busy;
    int          n_busy;

    initial begin
        bounce_pat  = 12'b1101_1101_0000;
        bounce_busy = 12'b0011_0111_0100;
        glitch_pat  = 5'b01111;
        glitch_busy = 5'b00100;

        // 1. Reset held with sw = 1, then clean rise.
        sw = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk_out("t1_in_reset", 1'b0, 1'b0);
        end
        reset = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            cyc(1'b1);
            chk_out($sformatf("t1_rise_e%0d", i), (i == 7), (i >= 3 && i < 7));
        end
        repeat (3) begin
            cyc(1'b1);
            chk_out("t1_hold", 1'b1, 1'b0);
        end

        // 3. Clean fall from ONE.
        for (int i = 1; i <= 7; i++) begin
            cyc(1'b0);
            chk_out($sformatf("t3_fall_e%0d", i), (i < 7), (i >= 3 && i < 7));
        end

        // 2. Bounce rejection from ZERO.
        for (int i = 0; i < 12; i++) begin
            cyc(bounce_pat[11-i]);
            chk_out($sformatf("t2_bounce_e%0d", i + 1), 1'b0, bounce_busy[11-i]);
        end

        // Back to ONE.
        repeat (7) cyc(1'b1);
        chk_out("rise_again", 1'b1, 1'b0);

        // 4. Single-cycle glitch low while in ONE.
        n_busy = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(glitch_pat[4-i]);
            if (db_busy) n_busy++;
            chk_out($sformatf("t4_glitch_e%0d", i + 1), 1'b1, glitch_busy[4-i]);
        end
        check("t4_busy_cycles", n_busy, 1);

        // Back to ZERO.
        repeat (7) cyc(1'b0);
        chk_out("fall_again", 1'b0, 1'b0);

        // 6a. Exactly DB_CYCLES samples in WAIT1: accepted.
        for (int i = 1; i <= 8; i++) begin
            cyc(i <= 5);
            if (i == 6) chk_out("t6_pass_e6", 1'b0, 1'b1);
            if (i == 7) chk_out("t6_pass_e7", 1'b1, 1'b0);
            if (i == 8) chk_out("t6_pass_e8", 1'b1, 1'b1);
        end
        repeat (6) cyc(1'b0);
        chk_out("t6_pass_settle", 1'b0, 1'b0);

        // 6b. One sample short: rejected.
        for (int i = 1; i <= 7; i++) begin
            cyc(i <= 4);
            if (i == 6) chk_out("t6_short_e6", 1'b0, 1'b1);
            if (i == 7) chk_out("t6_short_e7", 1'b0, 1'b0);
        end
        repeat (3) cyc(1'b0);
        chk_out("t6_short_settle", 1'b0, 1'b0);

        // 5. Asynchronous reset mid-wait (WAIT1, cnt = 2).
        for (int i = 1; i <= 5; i++) cyc(1'b1);
        chk_out("t5_wait1", 1'b0, 1'b1);
        #3 reset = 1'b0;
        #1 chk_out("t5_async_wait", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_out("t5_held", 1'b0, 1'b0);
        reset = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            cyc(1'b1);
            chk_out($sformatf("t5_rerise_e%0d", i), (i == 7), (i >= 3 && i < 7));
        end

        // Asynchronous reset while in ONE clears db_level without an edge.
        #2 reset = 1'b0;
        #1 chk_out("t5_async_one", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
